// File: rtl/vga_capture_pkg.sv
// Shared 640x480@60 timing constants, widths and capture state type for the VGA
// capture/transmit pair.
package vga_capture_pkg;

    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BACK      = 48;
    localparam int unsigned VGA_H_ACTIVE    = 640;
    localparam int unsigned VGA_H_TOTAL     = 800;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BACK      = 33;
    localparam int unsigned VGA_V_ACTIVE    = 480;
    localparam int unsigned VGA_V_TOTAL     = 525;
    localparam int unsigned VGA_LOCK_FRAMES = 2;

    localparam int unsigned PIX_W   = 11;
    localparam int unsigned LINE_W  = 10;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned COLOR_W = 12;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned ERR_W   = 8;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } cap_state_e;

    // Reduce RGB 4:4:4 to one bit per channel using each channel's MSB.
    function automatic logic [CODE_W-1:0] color_code(input logic [COLOR_W-1:0] rgb);
        return {rgb[11], rgb[7], rgb[3]};
    endfunction

endpackage

// File: rtl/vga_capture_sync_edge.sv
// sync_edge_detect: leading (1->0) edge detector for an active-low sync,
// advanced only on pixel strobes; history resets to idle-high.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pixel_en,
    input  logic i_sync,
    output logic o_edge_c
);

    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 1'b1;
        end else if (i_pixel_en) begin
            sync_q <= i_sync;
        end
    end

    assign o_edge_c = i_pixel_en & sync_q & ~i_sync;

endmodule

// File: rtl/vga_capture.sv
// VGA timing capture: measures line/frame totals, locks after consecutive good
// frames and emits framebuffer writes for active pixels. VGA_CAPTURE_ERR_EN adds o_err_count.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pixel_en,
    input  logic               i_h_sync,
    input  logic               i_v_sync,
    input  logic [COLOR_W-1:0] i_color,
    output logic [X_W-1:0]     o_coord_x,
    output logic [Y_W-1:0]     o_coord_y,
    output logic               o_wr_en,
    output logic [CODE_W-1:0]  o_wr_data,
    output logic               o_locked,
    output logic [PIX_W-1:0]   o_h_total,
    output logic [LINE_W-1:0]  o_v_total,
    output logic [ERR_W-1:0]   o_err_count
);

    localparam int unsigned GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;
    localparam logic [PIX_W-1:0]  H_TOT_L  = PIX_W'(H_TOTAL);
    localparam logic [LINE_W-1:0] V_TOT_L  = LINE_W'(V_TOTAL);
    localparam logic [PIX_W-1:0]  X_START  = PIX_W'(H_SYNC + H_BACK);
    localparam logic [PIX_W-1:0]  X_END    = PIX_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [LINE_W-1:0] Y_START  = LINE_W'(V_SYNC + V_BACK);
    localparam logic [LINE_W-1:0] Y_END    = LINE_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

    logic h_edge_c;
    logic v_edge_c;

    sync_edge_detect u_h_edge (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pixel_en (i_pixel_en),
        .i_sync     (i_h_sync),
        .o_edge_c   (h_edge_c)
    );

    sync_edge_detect u_v_edge (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pixel_en (i_pixel_en),
        .i_sync     (i_v_sync),
        .o_edge_c   (v_edge_c)
    );

    logic [PIX_W-1:0]  pix_q;
    logic [PIX_W-1:0]  pix_d;
    logic [PIX_W-1:0]  pix_inc_c;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;
    logic [LINE_W-1:0] line_inc_c;
    logic [LINE_W-1:0] v_meas_c;
    logic              h_bad_c;
    logic              v_bad_c;
    logic              active_c;
    logic              wr_c;

    // Counter next values; a v edge coinciding with an h edge counts the line it closes.
    always_comb begin
        pix_inc_c  = (pix_q == PIX_MAX) ? pix_q : pix_q + 1'b1;
        line_inc_c = (line_q == LINE_MAX) ? line_q : line_q + 1'b1;
        v_meas_c   = h_edge_c ? line_inc_c : line_q;
        pix_d      = h_edge_c ? '0 : pix_inc_c;
        line_d     = v_edge_c ? '0 : (h_edge_c ? line_inc_c : line_q);
        h_bad_c    = h_edge_c && (pix_inc_c != H_TOT_L);
        v_bad_c    = v_edge_c && (v_meas_c != V_TOT_L);
        active_c   = (pix_d >= X_START) && (pix_d < X_END) &&
                     (line_d >= Y_START) && (line_d < Y_END);
    end

    cap_state_e        state_q;
    cap_state_e        state_d;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_d;
    logic              frame_ok_q;
    logic              frame_ok_d;
    logic              loss_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_SEARCH;
            good_q     <= '0;
            frame_ok_q <= 1'b1;
            o_locked   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            frame_ok_q <= frame_ok_d;
            o_locked   <= (state_d == ST_LOCKED);
        end
    end

    // Lock FSM: frame_ok accumulates per-line checks until the closing v edge.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        frame_ok_d = frame_ok_q;
        loss_c     = 1'b0;
        if (i_pixel_en) begin
            case (state_q)
                ST_SEARCH: begin
                    if (v_edge_c) begin
                        state_d    = ST_MEASURE;
                        good_d     = '0;
                        frame_ok_d = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (h_bad_c) begin
                        frame_ok_d = 1'b0;
                    end
                    if (v_edge_c) begin
                        frame_ok_d = 1'b1;
                        if (frame_ok_q && !h_bad_c && !v_bad_c) begin
                            good_d = good_q + 1'b1;
                            if (good_q == GOOD_LAST) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (h_bad_c || v_bad_c) begin
                        state_d = ST_SEARCH;
                        loss_c  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    assign wr_c = i_pixel_en && (state_q == ST_LOCKED) && !h_bad_c && !v_bad_c && active_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_q     <= '0;
            line_q    <= '0;
            o_h_total <= '0;
            o_v_total <= '0;
            o_wr_en   <= 1'b0;
            o_coord_x <= '0;
            o_coord_y <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (i_pixel_en) begin
                pix_q  <= pix_d;
                line_q <= line_d;
                if (h_edge_c) begin
                    o_h_total <= pix_inc_c;
                end
                if (v_edge_c) begin
                    o_v_total <= v_meas_c;
                end
                if (wr_c) begin
                    o_wr_en   <= 1'b1;
                    o_coord_x <= X_W'(pix_d - X_START);
                    o_coord_y <= Y_W'(line_d - Y_START);
                    o_wr_data <= color_code(i_color);
                end
            end
        end
    end

`ifdef VGA_CAPTURE_ERR_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= '0;
        end else if (loss_c && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign o_err_count = err_q;
`else
    logic unused_loss_c;
    assign unused_loss_c = loss_c;
    assign o_err_count   = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Randomized bench for vga_capture on scaled-down timing; a frame-level
// reference model predicts writes into a scoreboard checked by a monitor.
module tb_vga_capture;

    localparam int unsigned HS = 4, HB = 3, HA = 8, HT = 20;
    localparam int unsigned VS = 2, VB = 3, VA = 6, VT = 14;
    localparam int unsigned LOCK = 2;
    localparam int X0 = HS + HB;
    localparam int Y0 = VS + VB;
    localparam int FULL = HA * VA;

    logic        i_clk;
    logic        i_rst;
    logic        i_pixel_en;
    logic        i_h_sync;
    logic        i_v_sync;
    logic [11:0] i_color;
    logic [9:0]  o_coord_x;
    logic [8:0]  o_coord_y;
    logic        o_wr_en;
    logic [2:0]  o_wr_data;
    logic        o_locked;
    logic [10:0] o_h_total;
    logic [9:0]  o_v_total;
    logic [7:0]  o_err_count;

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pixel_en  (i_pixel_en),
        .i_h_sync    (i_h_sync),
        .i_v_sync    (i_v_sync),
        .i_color     (i_color),
        .o_coord_x   (o_coord_x),
        .o_coord_y   (o_coord_y),
        .o_wr_en     (o_wr_en),
        .o_wr_data   (o_wr_data),
        .o_locked    (o_locked),
        .o_h_total   (o_h_total),
        .o_v_total   (o_v_total),
        .o_err_count (o_err_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wr_cnt = 0;
    int  gap    = 1;

    // Reference model: 0 search, 1 measure, 2 locked; line/frame lengths in samples.
    int m_st, m_good, m_sil, m_lif, m_err, m_htot, m_vtot;
    bit m_fok, m_ph, m_pv;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_good = 0; m_sil = 1; m_lif = 0; m_err = 0;
        m_htot = 0; m_vtot = 0; m_fok = 1'b1; m_ph = 1'b1; m_pv = 1'b1;
    endtask

    task automatic model_sample(input logic h, input logic v, output bit he, output bit ve);
        bit hbad, vbad;
        he = m_ph && !h;
        ve = m_pv && !v;
        m_ph = h;
        m_pv = v;
        if (he) begin
            m_htot = (m_sil > 2047) ? 2047 : m_sil;
            m_sil = 1;
        end else begin
            m_sil++;
        end
        if (ve) begin
            m_vtot = he ? ((m_lif + 1 > 1023) ? 1023 : m_lif + 1) : m_lif;
            m_lif = 0;
        end else if (he) begin
            m_lif = (m_lif + 1 > 1023) ? 1023 : m_lif + 1;
        end
        hbad = he && (m_htot != int'(HT));
        vbad = ve && (m_vtot != int'(VT));
        if (m_st == 2) begin
            if (hbad || vbad) begin
                m_st = 0;
`ifdef VGA_CAPTURE_ERR_EN
                if (m_err < 255) m_err++;
`endif
            end
        end else if (m_st == 1) begin
            if (hbad) m_fok = 1'b0;
            if (ve) begin
                if (m_fok && !vbad) m_good++;
                else m_good = 0;
                m_fok = 1'b1;
                if (m_good == int'(LOCK)) m_st = 2;
            end
        end else if (ve) begin
            m_st = 1;
            m_good = 0;
            m_fok = 1'b1;
        end
    endtask

    task automatic check_all_zero();
        check("rst_x", int'(o_coord_x), 0);
        check("rst_y", int'(o_coord_y), 0);
        check("rst_wr_en", int'(o_wr_en), 0);
        check("rst_wr_data", int'(o_wr_data), 0);
        check("rst_locked", int'(o_locked), 0);
        check("rst_h_total", int'(o_h_total), 0);
        check("rst_v_total", int'(o_v_total), 0);
        check("rst_err_count", int'(o_err_count), 0);
    endtask

    task automatic do_reset();
        i_pixel_en = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        check_all_zero();
        check("queue_empty_at_reset", exp_q.size(), 0);
    endtask

    task automatic drive_sample(input logic h, input logic v, input logic [11:0] c,
                                input int lx, input int ly);
        bit he, ve;
        int pre_st;
        logic [52:0] snap;
        wr_t e;
        pre_st = m_st;
        model_sample(h, v, he, ve);
        if (pre_st == 2 && m_st == 2 && lx >= 0 && lx < int'(HA) && ly >= 0 && ly < int'(VA)) begin
            e.x = 10'(lx);
            e.y = 9'(ly);
            e.d = {c[11], c[7], c[3]};
            exp_q.push_back(e);
        end
        i_pixel_en = 1'b1;
        i_h_sync = h;
        i_v_sync = v;
        i_color = c;
        @(posedge i_clk);
        @(negedge i_clk);
        i_pixel_en = 1'b0;
        if (he || ve) begin
            check("locked", int'(o_locked), (m_st == 2) ? 1 : 0);
            check("err_count", int'(o_err_count), m_err);
            if (he) check("h_total", int'(o_h_total), m_htot);
            if (ve) check("v_total", int'(o_v_total), m_vtot);
        end
        snap = {o_coord_x, o_coord_y, o_wr_data, o_locked, o_h_total, o_v_total, o_err_count};
        for (int k = 1; k < gap; k++) begin
            i_color = 12'($urandom);
            @(posedge i_clk);
            @(negedge i_clk);
            checks++;
            if ({o_coord_x, o_coord_y, o_wr_data, o_locked, o_h_total, o_v_total, o_err_count} != snap
                || o_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold: got %h wr_en=%b expected %h wr_en=0", {o_coord_x, o_coord_y,
                         o_wr_data, o_locked, o_h_total, o_v_total, o_err_count}, o_wr_en, snap);
            end
        end
    endtask

    task automatic drive_frame(input int short_line, input int rst_line, input bit corners,
                               input int exp_writes);
        int len;
        logic [11:0] c;
        wr_cnt = 0;
        for (int l = 0; l < int'(VT); l++) begin
            len = (l == short_line) ? int'(HT) - 1 : int'(HT);
            for (int p = 0; p < len; p++) begin
                if (l == rst_line && p == X0 + int'(HA) / 2) do_reset();
                c = 12'($urandom);
                if (corners && l == Y0 && p == X0) c = 12'hF0F;
                if (corners && l == Y0 + int'(VA) - 1 && p == X0 + int'(HA) - 1) c = 12'h0F0;
                drive_sample((p < int'(HS)) ? 1'b0 : 1'b1, (l < int'(VS)) ? 1'b0 : 1'b1, c,
                             p - X0, l - Y0);
            end
        end
        if (exp_writes >= 0) check("writes_per_frame", wr_cnt, exp_writes);
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) begin
            wr_t got;
            wr_t e;
            wr_cnt++;
            checks++;
            got = {o_coord_x, o_coord_y, o_wr_data};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got x=%0d y=%0d d=%b expected no write",
                         o_coord_x, o_coord_y, o_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (got != e) begin
                    errors++;
                    $display("FAIL write: got x=%0d y=%0d d=%b expected x=%0d y=%0d d=%b",
                             got.x, got.y, got.d, e.x, e.y, e.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    int exp_err1;

    initial begin
        i_rst = 1'b0;
        i_pixel_en = 1'b0;
        i_h_sync = 1'b1;
        i_v_sync = 1'b1;
        i_color = '0;
`ifdef VGA_CAPTURE_ERR_EN
        exp_err1 = 1;
`else
        exp_err1 = 0;
`endif
        @(negedge i_clk);
        do_reset();

        drive_frame(-1, -1, 1'b0, 0);
        drive_frame(-1, -1, 1'b0, 0);
        check("unlocked_before_frame3", int'(o_locked), 0);
        drive_frame(-1, -1, 1'b1, FULL);
        check("locked_frame3", int'(o_locked), 1);
        check("h_total_ideal", int'(o_h_total), int'(HT));
        check("v_total_ideal", int'(o_v_total), int'(VT));

        drive_frame(3, -1, 1'b0, 0);
        check("locked_after_short_line", int'(o_locked), 0);
        check("err_after_short_line", int'(o_err_count), exp_err1);
        drive_frame(-1, -1, 1'b0, 0);
        drive_frame(-1, -1, 1'b0, 0);
        drive_frame(-1, -1, 1'b0, FULL);
        check("relocked", int'(o_locked), 1);

        drive_frame(-1, Y0 + 2, 1'b0, -1);
        check("unlocked_after_reset", int'(o_locked), 0);
        drive_frame(-1, -1, 1'b0, 0);
        drive_frame(-1, -1, 1'b0, 0);
        drive_frame(-1, -1, 1'b0, FULL);

        gap = 4;
        drive_frame(-1, -1, 1'b1, FULL);
        drive_frame(-1, -1, 1'b0, FULL);
        gap = 1;
        check("gap_h_total", int'(o_h_total), int'(HT));
        check("gap_v_total", int'(o_v_total), int'(VT));
        check("gap_locked", int'(o_locked), 1);

        repeat (4) @(negedge i_clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be: H_SYNC=96, H_BACK=48, H_ACTIVE=640, H_TOTAL=800, V_SYNC=2, V_BACK=33, V_ACTIVE=480, V_TOTAL=525, LOCK_FRAMES=2 (consecutive good frames required for lock).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1: sole clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_pixel_en, in, 1: one-cycle pixel strobe; all video inputs are sampled only when it is high.
- i_h_sync, in, 1: active-low horizontal sync.
- i_v_sync, in, 1: active-low vertical sync.
- i_color, in, 12: RGB 4:4:4, ordered {R,G,B}.
- o_coord_x, out, 10: captured pixel column.
- o_coord_y, out, 9: captured pixel row.
- o_wr_en, out, 1: framebuffer write strobe.
- o_wr_data, out, 3: colour code {R,G,B}.
- o_locked, out, 1: timing lock indicator.
- o_h_total, out, 11: measured pixels per line.
- o_v_total, out, 10: measured lines per frame.
- o_err_count, out, 8: timing mismatch counter.

Function
REQ-003 Sync leading edges SHALL be detected as a 1->0 transition between consecutive i_pixel_en samples.
REQ-004 Pixel counter (11 b) SHALL clear to 0 on an h-sync leading edge, otherwise increment per sample, saturating at 2047.
REQ-005 Line counter (10 b) SHALL increment on each h-sync leading edge, clear to 0 on a v-sync leading edge, and saturate at 1023.
REQ-006 If the h and v leading edges occur in the same sample, the block SHALL apply both: pixel counter=0 and line counter=0.
REQ-007 On each h-sync leading edge, o_h_total SHALL load the pre-clear pixel count plus 1; on each v-sync leading edge, o_v_total SHALL load the pre-clear line count.
REQ-008 The state machine SHALL have states SEARCH, MEASURE and LOCKED; reset enters SEARCH.
REQ-009 SEARCH->MEASURE on the first v-sync leading edge; the good-frame count is cleared.
REQ-010 In MEASURE, at each v-sync edge: the frame is good if every line in it had h_total==H_TOTAL and v_total==V_TOTAL; good increments the count, bad clears it; count==LOCK_FRAMES moves to LOCKED.
REQ-011 In LOCKED, any line with h_total!=H_TOTAL, or any frame with v_total!=V_TOTAL, SHALL move to SEARCH and increment o_err_count (saturating at 255).
REQ-012 Active region: pixel count in [H_SYNC+H_BACK, +H_ACTIVE-1] and line count in [V_SYNC+V_BACK, +V_ACTIVE-1]; x = pixel count-(H_SYNC+H_BACK), y = line count-(V_SYNC+V_BACK).
REQ-013 o_wr_en SHALL pulse for exactly one i_clk cycle, in the cycle after an i_pixel_en sample that lies in the active region while LOCKED; o_coord_x, o_coord_y and o_wr_data={i_color[11],i_color[7],i_color[3]} SHALL be registered in the same cycle.
REQ-014 o_locked SHALL be high if and only if the state is LOCKED; it SHALL drop in the cycle after a mismatch is detected, and no write SHALL occur for that sample.
REQ-015 Cycles with i_pixel_en low SHALL leave all counters, the state and the outputs unchanged, except that o_wr_en returns to 0.

Reset
REQ-016 When i_rst is high on an i_clk edge, all counters, o_coord_x, o_coord_y, o_wr_data, o_wr_en, o_h_total, o_v_total and o_err_count SHALL become 0, state SHALL be SEARCH and o_locked 0, and the sync history SHALL become 1 (idle).
REQ-017 A reset asserted mid-frame SHALL abort capture immediately; relock SHALL require a new v-sync edge followed by LOCK_FRAMES good frames.

Configuration
REQ-018 With VGA_CAPTURE_ERR_EN defined, o_err_count SHALL behave per REQ-011; without it, o_err_count SHALL be tied to 0 and no counter SHALL be synthesised.

Structure
REQ-019 Package vga_capture_pkg SHALL hold the state enum type (SEARCH, MEASURE, LOCKED) and the 640x480@60 timing constants, shared with the VGA transmitter.
REQ-020 A sub-module sync_edge_detect (sampled on i_pixel_en, leading-edge pulse output, reset to idle-high) SHALL be instantiated twice, once for h-sync and once for v-sync.

Verification
REQ-021 Drive ideal 800x525 timing for 3 frames -> o_locked rises at the v-sync edge that starts frame 3, and o_h_total=800, o_v_total=525.
REQ-022 After lock, drive pixel (0,0) with i_color=12'hF0F and pixel (639,479) with 12'h0F0 -> writes occur with x=0, y=0, data=3'b101, and with x=639, y=479, data=3'b010; exactly 307200 o_wr_en pulses occur per frame.
REQ-023 While locked, drive one line of 799 pixels -> o_locked falls, o_err_count=1, and there are no writes until relock two good frames later.
REQ-024 Assert i_rst for 1 cycle in mid-frame line 200 -> all outputs are 0 the next cycle, and lock returns only after a v-sync edge plus 2 good frames.
REQ-025 Drive the h and v leading edges in the same sample, with i_pixel_en high for 1 cycle in 4 -> both counters clear, and outputs hold during the gap cycles.
